// File: rtl/rv32_program_encoder_pkg.sv
// Shared RV32I encoder types: opcodes, funct codes, instruction formats, loader FSM states.
// Also holds the signed-range helper used by the legality checks.
package rv32_program_encoder_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } opcode_t;

  // {funct7[5], funct3} for register/immediate ALU operations
  typedef enum logic [3:0] {
    F_ADD  = 4'b0000,
    F_SUB  = 4'b1000,
    F_SLL  = 4'b0001,
    F_SLT  = 4'b0010,
    F_SLTU = 4'b0011,
    F_XOR  = 4'b0100,
    F_SRL  = 4'b0101,
    F_SRA  = 4'b1101,
    F_OR   = 4'b0110,
    F_AND  = 4'b0111
  } funct_t;

  typedef enum logic [3:0] {
    FMT_R, FMT_I, FMT_ISH, FMT_L, FMT_S, FMT_B, FMT_J, FMT_JR, FMT_U
  } instr_fmt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } enc_state_t;

  // True when imm is representable as a signed value of the given bit width.
  function automatic logic imm_fits(input logic [31:0] imm, input int unsigned bits);
    logic signed [31:0] s;
    s = $signed(imm) >>> (bits - 1);
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/rv32_field_pack.sv
// Combinational RV32I field packer: decoded fields in, 32-bit word and illegal flag out.
module rv32_field_pack
  import rv32_program_encoder_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [3:0]  funct,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  instr_fmt_t fmt;
  logic       known;
  logic [2:0] f3;

  assign f3 = funct[2:0];

  always_comb begin
    fmt   = FMT_R;
    known = 1'b1;
    case (opcode_t'(opcode))
      OP_REG:    fmt = FMT_R;
      OP_IMM:    fmt = (f3[1:0] == 2'b01) ? FMT_ISH : FMT_I;
      OP_LOAD:   fmt = FMT_L;
      OP_JALR:   fmt = FMT_JR;
      OP_STORE:  fmt = FMT_S;
      OP_BRANCH: fmt = FMT_B;
      OP_JAL:    fmt = FMT_J;
      OP_LUI,
      OP_AUIPC:  fmt = FMT_U;
      default:   known = 1'b0;
    endcase
  end

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (fmt)
      FMT_R: begin
        word    = {1'b0, funct[3], 5'b0, rs2, rs1, f3, rd, opcode};
        illegal = funct[3] && (f3 != 3'b000) && (f3 != 3'b101);
      end
      FMT_I: begin
        word    = {imm[11:0], rs1, f3, rd, opcode};
        illegal = funct[3] || !imm_fits(imm, 12);
      end
      FMT_ISH: begin
        // Only SRAI may set funct7[5]; shift amount must be 0..31.
        word    = {1'b0, funct[3], 5'b0, imm[4:0], rs1, f3, rd, opcode};
        illegal = (funct[3] && (funct != F_SRA)) || (imm[31:5] != '0);
      end
      FMT_L: begin
        word    = {imm[11:0], rs1, f3, rd, opcode};
        illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || !imm_fits(imm, 12);
      end
      FMT_JR: begin
        word    = {imm[11:0], rs1, 3'b000, rd, opcode};
        illegal = !imm_fits(imm, 12);
      end
      FMT_S: begin
        word    = {imm[11:5], rs2, rs1, f3, imm[4:0], opcode};
        illegal = (f3 > 3'b010) || !imm_fits(imm, 12);
      end
      FMT_B: begin
        word    = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opcode};
        illegal = (f3 == 3'b010) || (f3 == 3'b011) || !imm_fits(imm, 13) || imm[0];
      end
      FMT_J: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        illegal = !imm_fits(imm, 21) || imm[0];
      end
      FMT_U: begin
        word    = {imm[31:12], rd, opcode};
        illegal = (imm[11:0] != '0);
      end
      default: illegal = 1'b1;
    endcase
    if (!known) illegal = 1'b1;
  end

endmodule

// File: rtl/rv32_program_encoder.sv
// Program loader: accepts field bundles, encodes them and writes legal words to
// instruction memory at consecutive word addresses. state_dbg exposes the FSM.
// Handshake: a bundle transfers on a rising edge where in_valid && in_ready; in_ready
// depends only on the FSM state, and in_valid must hold with stable fields until then.
module rv32_program_encoder
  import rv32_program_encoder_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             finish,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [3:0]       in_funct,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             err,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             full,
  output logic [7:0]       err_count,
  output logic [1:0]       state_dbg
);

  enc_state_t  state;
  logic [31:0] word;
  logic        illegal;
  logic        accept;

  rv32_field_pack u_pack (
    .opcode  (in_opcode),
    .funct   (in_funct),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .imm     (in_imm),
    .word    (word),
    .illegal (illegal)
  );

  assign in_ready  = (state == LOAD);
  assign busy      = (state != IDLE);
  assign full      = (count == CNT_W'(DEPTH));
  assign state_dbg = state;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      err_count <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            count     <= '0;
            err_count <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (illegal) begin
              err <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end else begin
              mem_we    <= 1'b1;
              mem_wdata <= word;
              mem_addr  <= BASE_ADDR + (32'(count) << 2);
              count     <= count + CNT_W'(1);
              if (count == CNT_W'(DEPTH - 1)) state <= FULL;
            end
          end
          // finish wins over the FULL transition; an accepted word still goes out
          if (finish) state <= IDLE;
        end
        FULL: begin
          if (finish) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_program_encoder.sv
// Directed bench for rv32_program_encoder (DEPTH=4): expected writes/errors go into a
// queue, a negedge monitor pops and compares every DUT output event.
module tb_rv32_program_encoder;
  import rv32_program_encoder_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int W     = 65;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             finish = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [6:0]       in_opcode = '0;
  logic [3:0]       in_funct = '0;
  logic [4:0]       in_rd = '0;
  logic [4:0]       in_rs1 = '0;
  logic [4:0]       in_rs2 = '0;
  logic [31:0]      in_imm = '0;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             err;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             full;
  logic [7:0]       err_count;
  logic [1:0]       state_dbg;

  logic [W-1:0] exp_q[$];  // {is_err, addr, wdata}
  int n_checks = 0;
  int n_fail   = 0;

  rv32_program_encoder #(.DEPTH(DEPTH), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct(in_funct), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .err(err), .count(count), .busy(busy), .full(full),
    .err_count(err_count), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (mem_we || err) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got mem_we=%0b err=%0b addr=0x%08h wdata=0x%08h expected no output",
                 mem_we, err, mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("err_flag", 32'(err), 32'(e[64]));
        chk("mem_we", 32'(mem_we), 32'(!e[64]));
        if (!e[64]) begin
          chk("mem_addr", mem_addr, e[63:32]);
          chk("mem_wdata", mem_wdata, e[31:0]);
        end
      end
    end
  end

  // driver tasks; all are entered and left 1 time unit after a rising edge
  task automatic set_fields(input logic [6:0] op, input logic [3:0] f, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    in_opcode = op; in_funct = f; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic send(input logic [6:0] op, input logic [3:0] f, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input logic is_err, input logic [31:0] addr, input logic [31:0] word);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got in_ready=0 expected 1 within 20 cycles");
    end else begin
      exp_q.push_back({is_err, addr, word});
      set_fields(op, f, rd, rs1, rs2, imm);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_finish();
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // session 1: single ADDI
    do_start();
    chk("s1_busy", 32'(busy), 1);
    chk("s1_ready", 32'(in_ready), 1);
    chk("s1_state", 32'(state_dbg), 32'(LOAD));
    send(OP_IMM, F_ADD, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0, 32'h0050_0093);
    chk("s1_count", 32'(count), 1);
    do_finish();
    chk("s1_idle", 32'(busy), 0);

    // session 2: fill to DEPTH, then hold off a 5th bundle
    do_start();
    chk("s2_count_clr", 32'(count), 0);
    send(OP_REG,    F_ADD,  5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h0, 32'h0020_81B3);
    send(OP_REG,    F_SUB,  5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h4, 32'h4020_81B3);
    send(OP_STORE,  4'b0010, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'h8, 32'h0020_A423);
    send(OP_BRANCH, 4'b0000, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'hC, 32'h0020_8463);
    chk("s2_full", 32'(full), 1);
    chk("s2_count", 32'(count), 4);
    chk("s2_state", 32'(state_dbg), 32'(FULL));
    set_fields(OP_IMM, F_ADD, 5'd1, 5'd0, 5'd0, 32'd5);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("s2_held_off", 32'(in_ready), 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("s2_count_hold", 32'(count), 4);
    do_finish();
    chk("s2_idle_busy", 32'(busy), 0);
    chk("s2_idle_state", 32'(state_dbg), 32'(IDLE));

    // session 3: remaining formats plus illegal bundles
    do_start();
    send(OP_JAL, 4'b0000, 5'd1, 5'd0, 5'd0, 32'h800,      1'b0, 32'h0, 32'h0010_00EF);
    send(OP_LUI, 4'b0000, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0, 32'h4, 32'h1234_52B7);
    send(OP_IMM, F_SRA,   5'd1, 5'd1, 5'd0, 32'd3,        1'b0, 32'h8, 32'h4030_D093);
    send(OP_BRANCH, 4'b0000, 5'd0, 5'd1, 5'd2, 32'd7,    1'b1, 32'h0, 32'h0);
    chk("s3_err_cnt1", 32'(err_count), 1);
    send(OP_IMM, F_ADD, 5'd1, 5'd0, 5'd0, 32'd2048,      1'b1, 32'h0, 32'h0);
    send(OP_LOAD, 4'b0011, 5'd1, 5'd2, 5'd0, 32'd0,      1'b1, 32'h0, 32'h0);
    chk("s3_err_count", 32'(err_count), 3);
    chk("s3_count", 32'(count), 3);
    chk("s3_not_full", 32'(full), 0);
    do_finish();

    // reset right after an accept drops the pending write
    do_start();
    set_fields(OP_IMM, F_ADD, 5'd1, 5'd0, 5'd0, 32'd5);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rr_mem_we", 32'(mem_we), 0);
    chk("rr_mem_addr", mem_addr, 0);
    chk("rr_mem_wdata", mem_wdata, 0);
    chk("rr_count", 32'(count), 0);
    chk("rr_err_count", 32'(err_count), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rr_busy", 32'(busy), 0);
    @(posedge clk); #1;
    chk("rr_ready", 32'(in_ready), 0);

    repeat (3) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
